// File: rtl/cmp_iter.sv
// Iterative unsigned N-bit magnitude comparator: one 4-bit digit per cycle,
// MSB digit first, early exit on the first unequal digit, req/ack handshake.

module cmp_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       lth,
    output logic       equ,
    output logic       gth
);
    assign lth = (a < b);
    assign equ = (a == b);
    assign gth = (a > b);
endmodule

module cmp_iter #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         ack,
    output logic         lth,
    output logic         equ,
    output logic         gth
);
    localparam int D  = N / 4;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  y_q, y_d;
    logic          ack_q, ack_d;
    logic          lth_q, lth_d;
    logic          equ_q, equ_d;
    logic          gth_q, gth_d;

    logic [N-1:0]  x_sh, y_sh;
    logic          c_lth, c_equ, c_gth;

    assign x_sh = x_q >> {idx_q, 2'b00};
    assign y_sh = y_q >> {idx_q, 2'b00};

    cmp_4bit u_cmp (
        .a   (x_sh[3:0]),
        .b   (y_sh[3:0]),
        .lth (c_lth),
        .equ (c_equ),
        .gth (c_gth)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        ack_d   = ack_q;
        lth_d   = lth_q;
        equ_d   = equ_q;
        gth_d   = gth_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    x_d     = x;
                    y_d     = y;
                    idx_d   = LAST;
                    lth_d   = 1'b0;
                    equ_d   = 1'b0;
                    gth_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!c_equ) begin
                    lth_d   = c_lth;
                    gth_d   = c_gth;
                    equ_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    lth_d   = 1'b0;
                    gth_d   = 1'b0;
                    equ_d   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                // Result stays up until the requester lowers req.
                if (!req) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ack_q   <= 1'b0;
            lth_q   <= 1'b0;
            equ_q   <= 1'b0;
            gth_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ack_q   <= ack_d;
            lth_q   <= lth_d;
            equ_q   <= equ_d;
            gth_q   <= gth_d;
        end
    end

    assign ack = ack_q;
    assign lth = lth_q;
    assign equ = equ_q;
    assign gth = gth_q;
endmodule

// File: tb/tb_cmp_iter.sv
// Self-checking bench for cmp_iter: directed scenarios plus random pairs
// checked against an arithmetic model of result and latency.

module tb_cmp_iter;
    localparam int N = 16;
    localparam int D = N / 4;
    localparam int BOUND = 2 * D + 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         ack;
    logic         lth;
    logic         equ;
    logic         gth;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmp_iter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .x   (x),
        .y   (y),
        .ack (ack),
        .lth (lth),
        .equ (equ),
        .gth (gth)
    );

    // Latency = number of digits from the top down to the highest
    // differing digit, or all D digits when the operands are equal.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic el, output logic ee,
                                  output logic eg, output int k);
        int v;
        int bl;
        v  = int'(a ^ b);
        bl = 0;
        while ((v >> bl) != 0) bl++;
        el = (a < b);
        ee = (a == b);
        eg = (a > b);
        k  = (v == 0) ? D : D - (bl - 1) / 4;
    endfunction

    // Starts at a falling edge with the DUT idle; returns at the falling
    // edge where ack is first seen, k = edges after acceptance.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         output int k, output bit to);
        x   = a;
        y   = b;
        req = 1'b1;
        k   = -1;
        to  = 1'b1;
        for (int c = 0; c <= BOUND; c++) begin
            @(negedge clk);
            if (ack) begin
                k  = c;
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 1'b1;
        x   = N'($urandom);
        y   = N'($urandom);
        repeat (2) @(negedge clk);
        checks++;
        if ({ack, lth, equ, gth} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000", {ack, lth, equ, gth});
        end
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle ack got %b want 0", ack);
        end
    endtask

    task automatic test_equal();
        int  k;
        bit  to;
        issue(16'h1234, 16'h1234, k, to);
        checks++;
        if (to || k != 4) begin
            errors++;
            $display("FAIL equal_latency got %0d want 4 (timeout=%0d)", k, to);
        end
        checks++;
        if ({lth, equ, gth} !== 3'b010) begin
            errors++;
            $display("FAIL equal_flags got %b want 010", {lth, equ, gth});
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold();
        int  k;
        bit  to;
        issue(16'h8000, 16'h7FFF, k, to);
        checks++;
        if (to || k != 1) begin
            errors++;
            $display("FAIL hold_latency got %0d want 1 (timeout=%0d)", k, to);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({ack, lth, equ, gth} !== 4'b1001) begin
                errors++;
                $display("FAIL hold_cycle%0d got %b want 1001", i, {ack, lth, equ, gth});
            end
        end
        req = 1'b0;
        @(negedge clk);
        checks++;
        if ({ack, lth, equ, gth} !== 4'b0001) begin
            errors++;
            $display("FAIL hold_release got %b want 0001", {ack, lth, equ, gth});
        end
        @(negedge clk);
        checks++;
        if ({ack, gth} !== 2'b01) begin
            errors++;
            $display("FAIL hold_idle_keep got %b want 01", {ack, gth});
        end
    endtask

    task automatic test_operand_change();
        bit ok;
        ok  = 1'b0;
        x   = 16'h1230;
        y   = 16'h1231;
        req = 1'b1;
        @(negedge clk);
        x = 16'hFFFF;
        y = 16'h0000;
        for (int c = 1; c <= BOUND; c++) begin
            @(negedge clk);
            if (ack) begin
                checks++;
                if (c != 4) begin
                    errors++;
                    $display("FAIL opchg_latency got %0d want 4", c);
                end
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || {lth, equ, gth} !== 3'b100) begin
            errors++;
            $display("FAIL opchg_flags got %b ack=%b want 100", {lth, equ, gth}, ok);
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int  k;
        bit  to;
        x   = 16'h0001;
        y   = 16'h0002;
        req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre ack got %b want 0", ack);
        end
        rst = 1'b0;
        req = 1'b0;
        @(negedge clk);
        checks++;
        if ({ack, lth, equ, gth} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_outputs got %b want 0000", {ack, lth, equ, gth});
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("FAIL midrst_noack got %b want 0", ack);
            end
        end
        issue(16'h00F0, 16'h00E0, k, to);
        checks++;
        if (to || k != 3 || {lth, equ, gth} !== 3'b001) begin
            errors++;
            $display("FAIL midrst_next got k=%0d flags=%b want k=3 flags=001", k, {lth, equ, gth});
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop_in_run();
        logic [N-1:0] a, b;
        logic el, ee, eg;
        int   k, ek, seen;
        bit   to;
        x    = 16'hFFFF;
        y    = 16'hFFFE;
        req  = 1'b1;
        seen = -1;
        @(negedge clk);
        req = 1'b0;
        for (int c = 1; c <= BOUND; c++) begin
            @(negedge clk);
            if (ack) begin
                seen = c;
                break;
            end
        end
        checks++;
        if (seen != 4 || {lth, equ, gth} !== 3'b001) begin
            errors++;
            $display("FAIL drop_result got k=%0d flags=%b want k=4 flags=001", seen, {lth, equ, gth});
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL drop_one_cycle ack got %b want 0", ack);
        end
        a = N'($urandom);
        b = N'($urandom);
        model(a, b, el, ee, eg, ek);
        issue(a, b, k, to);
        checks++;
        if (to || k != ek || {lth, equ, gth} !== {el, ee, eg}) begin
            errors++;
            $display("FAIL drop_next got k=%0d flags=%b want k=%0d flags=%b",
                     k, {lth, equ, gth}, ek, {el, ee, eg});
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [N-1:0] a, b;
        logic el, ee, eg;
        int   k, ek, mode, dig;
        bit   to;
        for (int i = 0; i < 60; i++) begin
            a    = N'($urandom);
            mode = int'($urandom_range(0, 2));
            dig  = int'($urandom_range(0, D - 1));
            if (mode == 0) b = N'($urandom);
            else if (mode == 1) b = a;
            else b = a ^ (N'($urandom_range(1, 15)) << (4 * dig));
            model(a, b, el, ee, eg, ek);
            issue(a, b, k, to);
            checks++;
            if (to || k != ek) begin
                errors++;
                $display("FAIL rand%0d_latency a=%h b=%h got %0d want %0d", i, a, b, k, ek);
            end
            checks++;
            if ({lth, equ, gth} !== {el, ee, eg}) begin
                errors++;
                $display("FAIL rand%0d_flags a=%h b=%h got %b want %b",
                         i, a, b, {lth, equ, gth}, {el, ee, eg});
            end
            req = 1'b0;
            @(negedge clk);
            checks++;
            if (ack !== 1'b0 || {lth, equ, gth} !== {el, ee, eg}) begin
                errors++;
                $display("FAIL rand%0d_idle got ack=%b flags=%b want ack=0 flags=%b",
                         i, ack, {lth, equ, gth}, {el, ee, eg});
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        req = 1'b0;
        x   = '0;
        y   = '0;
        @(negedge clk);
        test_reset();
        test_equal();
        test_hold();
        test_operand_change();
        test_reset_mid_run();
        test_drop_in_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
